// File: rtl/wash_cycle_controller.sv
// wash_cycle_controller: self-timed washing-machine sequencer.
// Soap fill -> detergent wait -> wash -> drain -> N rinse passes -> spin -> done.
// A shared countdown timer times the wash, rinse and spin states. Pause freezes
// progress, an open door forces FAULT, and all outputs are registered.
// Optional feature macro: WASH_WATCHDOG_EN. When it is defined, the fill and
// drain states time out to FAULT if their sensor never arrives.
//
// There is no valid/ready handshake here. The sensor inputs are level-sampled
// on each unpaused rising edge. A sensor that is high when a state is entered
// advances on the next unpaused edge.
module wash_cycle_controller #(
  parameter int TIMER_W     = 16,
  parameter int WASH_TICKS  = 1000,
  parameter int RINSE_TICKS = 500,
  parameter int SPIN_TICKS  = 300,
  parameter int FILL_LIMIT  = 2000,
  parameter int DRAIN_LIMIT = 2000,
  parameter int RINSE_W     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               door_close,
  input  logic               pause,
  input  logic [RINSE_W-1:0] rinse_count,
  input  logic               filled,
  input  logic               detergent_added,
  input  logic               drained,
  output logic               door_lock,
  output logic               motor_on,
  output logic               fill_valve_on,
  output logic               drain_valve_on,
  output logic               soap_wash,
  output logic               water_wash,
  output logic               done,
  output logic               fault,
  output logic [3:0]         state,
  output logic [RINSE_W-1:0] rinse_left
);

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_FILL_SOAP   = 4'd1,
    S_WAIT_DET    = 4'd2,
    S_WASH        = 4'd3,
    S_DRAIN_SOAP  = 4'd4,
    S_FILL_RINSE  = 4'd5,
    S_RINSE       = 4'd6,
    S_DRAIN_RINSE = 4'd7,
    S_SPIN        = 4'd8,
    S_DONE        = 4'd9,
    S_FAULT       = 4'd10
  } state_e;

  typedef struct packed {
    logic lock;
    logic motor;
    logic fill;
    logic drain;
    logic soap;
    logic water;
    logic done;
    logic fault;
  } out_t;

  // Timer reload values; the dwell is load+1 unpaused cycles.
  localparam logic [TIMER_W-1:0] WASH_LOAD  = TIMER_W'(WASH_TICKS - 1);
  localparam logic [TIMER_W-1:0] RINSE_LOAD = TIMER_W'(RINSE_TICKS - 1);
  localparam logic [TIMER_W-1:0] SPIN_LOAD  = TIMER_W'(SPIN_TICKS - 1);
  localparam logic [TIMER_W-1:0] FILL_LOAD  = TIMER_W'(FILL_LIMIT - 1);
  localparam logic [TIMER_W-1:0] DRAIN_LOAD = TIMER_W'(DRAIN_LIMIT - 1);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [RINSE_W-1:0] rinse_q, rinse_d;
  out_t               out_q, out_d;

  logic               timer_zero;
  logic [TIMER_W-1:0] timer_dec;
  logic [RINSE_W-1:0] rinse_dec;
  logic               active_d;

  assign timer_zero = (timer_q == '0);
  assign timer_dec  = timer_q - TIMER_W'(1);
  assign rinse_dec  = (rinse_q != '0) ? (rinse_q - RINSE_W'(1)) : rinse_q;

  // State register, timer, rinse counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      rinse_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rinse_q <= rinse_d;
      out_q   <= out_d;
    end
  end

  // Next-state, timer and rinse-count logic. Door fault outranks pause, sensors and timer.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rinse_d = rinse_q;
    case (state_q)
      S_IDLE: begin
        if (start && door_close) begin
          state_d = S_FILL_SOAP;
          rinse_d = rinse_count;
        end
      end
      S_DONE: if (!start) state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: begin
        if (!door_close) begin
          state_d = S_FAULT;
        end else if (!pause) begin
          case (state_q)
            S_FILL_SOAP, S_FILL_RINSE: begin
              if (filled) begin
                state_d = (state_q == S_FILL_SOAP) ? S_WAIT_DET : S_RINSE;
`ifdef WASH_WATCHDOG_EN
              end else if (timer_zero) begin
                state_d = S_FAULT;
              end else begin
                timer_d = timer_dec;
`endif
              end
            end
            S_WAIT_DET: if (detergent_added) state_d = S_WASH;
            S_DRAIN_SOAP: begin
              if (drained) begin
                state_d = (rinse_q != '0) ? S_FILL_RINSE : S_SPIN;
`ifdef WASH_WATCHDOG_EN
              end else if (timer_zero) begin
                state_d = S_FAULT;
              end else begin
                timer_d = timer_dec;
`endif
              end
            end
            S_DRAIN_RINSE: begin
              if (drained) begin
                rinse_d = rinse_dec;
                state_d = (rinse_dec != '0) ? S_FILL_RINSE : S_SPIN;
`ifdef WASH_WATCHDOG_EN
              end else if (timer_zero) begin
                state_d = S_FAULT;
              end else begin
                timer_d = timer_dec;
`endif
              end
            end
            S_WASH:  if (timer_zero) state_d = S_DRAIN_SOAP; else timer_d = timer_dec;
            S_RINSE: if (timer_zero) state_d = S_DRAIN_RINSE; else timer_d = timer_dec;
            S_SPIN:  if (timer_zero) state_d = S_DONE; else timer_d = timer_dec;
            default: state_d = state_q;
          endcase
        end
      end
    endcase
    // Reload the timer on entry to any state that uses it. Without the
    // watchdog, the fill/drain load is simply never counted down.
    if (state_d != state_q) begin
      case (state_d)
        S_WASH:                        timer_d = WASH_LOAD;
        S_RINSE:                       timer_d = RINSE_LOAD;
        S_SPIN:                        timer_d = SPIN_LOAD;
        S_FILL_SOAP, S_FILL_RINSE:     timer_d = FILL_LOAD;
        S_DRAIN_SOAP, S_DRAIN_RINSE:   timer_d = DRAIN_LOAD;
        default:                       timer_d = timer_q;
      endcase
    end
  end

  // Output decode from the next state. Pause gates the actuators for running states.
  always_comb begin
    out_d    = '0;
    active_d = (state_d >= S_FILL_SOAP) && (state_d <= S_SPIN);
    case (state_d)
      S_FILL_SOAP:   begin out_d.lock = 1'b1; out_d.fill  = 1'b1; out_d.soap  = 1'b1; end
      S_WAIT_DET:    begin out_d.lock = 1'b1; out_d.soap  = 1'b1; end
      S_WASH:        begin out_d.lock = 1'b1; out_d.motor = 1'b1; out_d.soap  = 1'b1; end
      S_DRAIN_SOAP:  begin out_d.lock = 1'b1; out_d.drain = 1'b1; out_d.soap  = 1'b1; end
      S_FILL_RINSE:  begin out_d.lock = 1'b1; out_d.fill  = 1'b1; out_d.water = 1'b1; end
      S_RINSE:       begin out_d.lock = 1'b1; out_d.motor = 1'b1; out_d.water = 1'b1; end
      S_DRAIN_RINSE: begin out_d.lock = 1'b1; out_d.drain = 1'b1; out_d.water = 1'b1; end
      S_SPIN:        begin out_d.lock = 1'b1; out_d.motor = 1'b1; out_d.drain = 1'b1; end
      S_DONE:        out_d.done = 1'b1;
      S_FAULT:       begin out_d.fault = 1'b1; out_d.drain = 1'b1; end
      default:       out_d = '0;
    endcase
    if (pause && active_d) begin
      out_d.motor = 1'b0;
      out_d.fill  = 1'b0;
      out_d.drain = 1'b0;
    end
  end

  assign door_lock      = out_q.lock;
  assign motor_on       = out_q.motor;
  assign fill_valve_on  = out_q.fill;
  assign drain_valve_on = out_q.drain;
  assign soap_wash      = out_q.soap;
  assign water_wash     = out_q.water;
  assign done           = out_q.done;
  assign fault          = out_q.fault;
  assign state          = state_q;
  assign rinse_left     = rinse_q;

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Directed testbench for wash_cycle_controller with small tick counts.
module tb_wash_cycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, door_close, pause;
  logic [1:0] rinse_count;
  logic       filled, detergent_added, drained;
  logic       door_lock, motor_on, fill_valve_on, drain_valve_on;
  logic       soap_wash, water_wash, done, fault;
  logic [3:0] state;
  logic [1:0] rinse_left;

  int tests_run = 0;
  int tests_failed = 0;

  // clock / reset
  always #5 clk = ~clk;

  wash_cycle_controller #(
    .TIMER_W(8), .WASH_TICKS(4), .RINSE_TICKS(3), .SPIN_TICKS(2),
    .FILL_LIMIT(8), .DRAIN_LIMIT(8), .RINSE_W(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .door_close(door_close),
    .pause(pause), .rinse_count(rinse_count), .filled(filled),
    .detergent_added(detergent_added), .drained(drained),
    .door_lock(door_lock), .motor_on(motor_on), .fill_valve_on(fill_valve_on),
    .drain_valve_on(drain_valve_on), .soap_wash(soap_wash), .water_wash(water_wash),
    .done(done), .fault(fault), .state(state), .rinse_left(rinse_left)
  );

  // Expected {lock,motor,fill,drain,soap,water,done,fault} per state, unpaused.
  function automatic logic [7:0] exp_out(input int s);
    case (s)
      1:  exp_out = 8'b1010_1000;
      2:  exp_out = 8'b1000_1000;
      3:  exp_out = 8'b1100_1000;
      4:  exp_out = 8'b1001_1000;
      5:  exp_out = 8'b1010_0100;
      6:  exp_out = 8'b1100_0100;
      7:  exp_out = 8'b1001_0100;
      8:  exp_out = 8'b1101_0000;
      9:  exp_out = 8'b0000_0010;
      10: exp_out = 8'b0001_0001;
      default: exp_out = 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [7:0] obs_out();
    obs_out = {door_lock, motor_on, fill_valve_on, drain_valve_on,
               soap_wash, water_wash, done, fault};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0; door_close = 1'b1; pause = 1'b0; rinse_count = 2'd0;
    filled = 1'b0; detergent_added = 1'b0; drained = 1'b0;
    repeat (2) step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (state !== 4'd0 || obs_out() !== 8'h00 || rinse_left !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset: state=%0d outs=%b rinse_left=%0d, required state=0 outs=0 rinse_left=0",
               state, obs_out(), rinse_left);
    end
  endtask

  task automatic test_normal();
    int exp_seq [20] = '{1,2,3,3,3,3,4,5,6,6,6,7,5,6,6,6,7,8,8,9};
    do_reset();
    filled = 1'b1; detergent_added = 1'b1; drained = 1'b1;
    rinse_count = 2'd2; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      tests_run++;
      if (state !== exp_seq[i][3:0] || obs_out() !== exp_out(exp_seq[i])) begin
        tests_failed++;
        $display("FAIL normal[%0d]: state=%0d outs=%b, required state=%0d outs=%b",
                 i, state, obs_out(), exp_seq[i], exp_out(exp_seq[i]));
      end
      if (i == 0) begin
        tests_run++;
        if (rinse_left !== 2'd2) begin
          tests_failed++;
          $display("FAIL normal_capture: rinse_left=%0d, required 2", rinse_left);
        end
      end
    end
    tests_run++;
    if (rinse_left !== 2'd0) begin
      tests_failed++;
      $display("FAIL normal_rinse_left: rinse_left=%0d, required 0", rinse_left);
    end
    start = 1'b0;
    step();
    tests_run++;
    if (state !== 4'd0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL normal_to_idle: state=%0d done=%b, required state=0 done=0", state, done);
    end
  endtask

  task automatic test_zero_rinse();
    int exp_seq [10] = '{1,2,3,3,3,3,4,8,8,9};
    logic saw_water;
    saw_water = 1'b0;
    do_reset();
    filled = 1'b1; detergent_added = 1'b1; drained = 1'b1;
    rinse_count = 2'd0; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      saw_water = saw_water | water_wash;
      tests_run++;
      if (state !== exp_seq[i][3:0]) begin
        tests_failed++;
        $display("FAIL zero_rinse[%0d]: state=%0d, required %0d", i, state, exp_seq[i]);
      end
    end
    tests_run++;
    if (saw_water !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_rinse_water: water_wash seen=%b, required 0", saw_water);
    end
  endtask

  task automatic test_pause();
    int wash_cycles;
    wash_cycles = 0;
    do_reset();
    filled = 1'b1; detergent_added = 1'b1; drained = 1'b1;
    rinse_count = 2'd0; start = 1'b1;
    repeat (4) begin
      step();
      if (state == 4'd3) wash_cycles++;
    end
    // Now in WASH with timer=2.
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (state == 4'd3) wash_cycles++;
      tests_run++;
      if (state !== 4'd3 || motor_on !== 1'b0 || door_lock !== 1'b1 || soap_wash !== 1'b1) begin
        tests_failed++;
        $display("FAIL pause_hold[%0d]: state=%0d motor=%b lock=%b soap=%b, required 3 0 1 1",
                 i, state, motor_on, door_lock, soap_wash);
      end
    end
    pause = 1'b0;
    step();
    if (state == 4'd3) wash_cycles++;
    tests_run++;
    if (state !== 4'd3 || motor_on !== 1'b1) begin
      tests_failed++;
      $display("FAIL pause_release: state=%0d motor=%b, required 3 1", state, motor_on);
    end
    step();
    if (state == 4'd3) wash_cycles++;
    step();
    tests_run++;
    if (state !== 4'd4) begin
      tests_failed++;
      $display("FAIL pause_exit: state=%0d, required 4", state);
    end
    tests_run++;
    if (wash_cycles !== 9) begin
      tests_failed++;
      $display("FAIL pause_dwell: wash cycles=%0d, required 9", wash_cycles);
    end
  endtask

  task automatic test_door_fault();
    do_reset();
    filled = 1'b1; detergent_added = 1'b1; drained = 1'b1;
    rinse_count = 2'd1; start = 1'b1;
    repeat (9) step();
    tests_run++;
    if (state !== 4'd6) begin
      tests_failed++;
      $display("FAIL fault_setup: state=%0d, required 6", state);
    end
    door_close = 1'b0;
    step();
    tests_run++;
    if (state !== 4'd10 || fault !== 1'b1 || drain_valve_on !== 1'b1 || motor_on !== 1'b0) begin
      tests_failed++;
      $display("FAIL door_fault: state=%0d fault=%b drain=%b motor=%b, required 10 1 1 0",
               state, fault, drain_valve_on, motor_on);
    end
    door_close = 1'b1; start = 1'b0;
    repeat (3) step();
    tests_run++;
    if (state !== 4'd10 || obs_out() !== 8'b0001_0001) begin
      tests_failed++;
      $display("FAIL fault_sticky: state=%0d outs=%b, required 10 00010001", state, obs_out());
    end
    reset = 1'b0;
    #2;
    tests_run++;
    if (state !== 4'd0 || obs_out() !== 8'h00) begin
      tests_failed++;
      $display("FAIL fault_reset: state=%0d outs=%b, required 0 00000000", state, obs_out());
    end
    reset = 1'b1;
  endtask

  task automatic test_watchdog();
    do_reset();
    filled = 1'b0; rinse_count = 2'd0; start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      tests_run++;
      if (state !== 4'd1) begin
        tests_failed++;
        $display("FAIL wd_wait[%0d]: state=%0d, required 1", k, state);
      end
    end
`ifdef WASH_WATCHDOG_EN
    step();
    tests_run++;
    if (state !== 4'd10 || fault !== 1'b1) begin
      tests_failed++;
      $display("FAIL wd_expire: state=%0d fault=%b, required 10 1", state, fault);
    end
`else
    repeat (92) step();
    tests_run++;
    if (state !== 4'd1) begin
      tests_failed++;
      $display("FAIL wd_disabled: state=%0d after 100 cycles, required 1", state);
    end
`endif
  endtask

  // Sensor arriving on the same edge the watchdog hits zero advances normally.
  task automatic test_watchdog_race();
    do_reset();
    filled = 1'b0; rinse_count = 2'd0; start = 1'b1;
    repeat (8) step();
    filled = 1'b1;
    step();
    tests_run++;
    if (state !== 4'd2 || fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL wd_race: state=%0d fault=%b, required 2 0", state, fault);
    end
  endtask

  task automatic test_reset_mid_spin();
    do_reset();
    filled = 1'b1; detergent_added = 1'b1; drained = 1'b1;
    rinse_count = 2'd0; start = 1'b1;
    repeat (8) step();
    tests_run++;
    if (state !== 4'd8 || motor_on !== 1'b1) begin
      tests_failed++;
      $display("FAIL spin_setup: state=%0d motor=%b, required 8 1", state, motor_on);
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (state !== 4'd0 || obs_out() !== 8'h00 || rinse_left !== 2'd0) begin
      tests_failed++;
      $display("FAIL async_reset: state=%0d outs=%b rinse_left=%0d, required 0 00000000 0",
               state, obs_out(), rinse_left);
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_zero_rinse();
    test_pause();
    test_door_fault();
    test_watchdog();
    test_watchdog_race();
    test_reset_mid_spin();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
